// File: rtl/stack_pkg.sv
// rtl/stack_pkg.sv - shared op encodings, FSM states and default sizes for the return stack
package stack_pkg;

   localparam int DEPTH_DEF = 4;
   localparam int DW_DEF    = 12;

   typedef enum logic [1:0] {
      OP_NOP  = 2'b00,
      OP_PUSH = 2'b01,
      OP_POP  = 2'b10,
      OP_PEEK = 2'b11
   } op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_READ = 1'b1
   } state_e;

endpackage

// File: rtl/stack_ptr.sv
// rtl/stack_ptr.sv - occupancy counter with saturating inc/dec and full/empty/top decode
module stack_ptr
   import stack_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int AW    = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          inc,
   input  logic          dec,
   output logic [AW:0]   count,
   output logic [AW-1:0] top,
   output logic          full,
   output logic          empty
);

   logic [AW:0] cnt;

   // Saturation here is what keeps the storage index in range.
   always_ff @(posedge clk) begin
      if (rst)
         cnt <= '0;
      else if (inc && !full)
         cnt <= cnt + 1'b1;
      else if (dec && !empty)
         cnt <= cnt - 1'b1;
   end

   assign count = cnt;
   assign full  = (cnt == (AW+1)'(DEPTH));
   assign empty = (cnt == '0);
   assign top   = AW'(cnt - 1'b1);

endmodule

// File: rtl/stack_ctrl.sv
// rtl/stack_ctrl.sv - push/pop/peek sequencer for the 4-entry return stack storage
module stack_ctrl
   import stack_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int AW    = 2,
   parameter int DW    = DW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [1:0]    req_op,
   input  logic [DW-1:0] req_data,
   output logic          rsp_valid,
   output logic [DW-1:0] rsp_data,
   output logic [AW:0]   count,
   output logic          full,
   output logic          empty,
   output logic          ovf,
   output logic          udf,
   input  logic          err_clr,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   state_e        state;
   logic          zflag;
   op_e           op;
   logic          accept;
   logic          do_push;
   logic          do_rd;
   logic          do_pop;
   logic [AW-1:0] top;

   assign op        = op_e'(req_op);
   assign req_ready = (state == ST_IDLE);
   assign accept    = req_valid && req_ready;
   assign do_push   = accept && (op == OP_PUSH);
   assign do_pop    = accept && (op == OP_POP);
   assign do_rd     = accept && ((op == OP_POP) || (op == OP_PEEK));

   stack_ptr #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ptr (
      .clk   (clk),
      .rst   (rst),
      .inc   (do_push),
      .dec   (do_pop),
      .count (count),
      .top   (top),
      .full  (full),
      .empty (empty)
   );

   // Address parks at 0 unless a serviceable request is in its accept cycle.
   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (do_push && !full) begin
         mem_we    = 1'b1;
         mem_addr  = count[AW-1:0];
         mem_wdata = req_data;
      end else if (do_rd && !empty) begin
         mem_addr  = top;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         zflag <= 1'b0;
         ovf   <= 1'b0;
         udf   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (do_rd) begin
                  state <= ST_READ;
                  zflag <= empty;
               end
            end
            default: begin
               state <= ST_IDLE;
               zflag <= 1'b0;
            end
         endcase
         // A fresh error in the clear cycle takes precedence over err_clr.
         ovf <= (ovf && !err_clr) || (do_push && full);
         udf <= (udf && !err_clr) || (do_rd && empty);
      end
   end

   assign rsp_valid = (state == ST_READ);
   assign rsp_data  = ((state == ST_READ) && !zflag) ? mem_rdata : '0;

endmodule
